mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage of the 5-stage MIPS core, directly downstream of the execute stage. It registers the execute-to-memory bus under pipeline stall control and takes synchronous data-SRAM read data. It extracts and extends byte, halfword or word load results and forwards the write-back candidate to decode. It also drives the memory-to-write-back bus.

## Interface
Parameters:
- none; widths come from shared constants: `EX_TO_MEM_WD` = 80, `MEM_TO_WB_WD` = 70, `StallBus` = 6.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  `StallBus`  per-stage stall vector; bit 3 = MEM, bit 4 = WB; `Stop` = 1.
- ex_to_mem_bus  in  80  fields:
  - [79:76] load_sel
  - [75:44] pc
  - [43] data_ram_en
  - [42:39] data_ram_wen
  - [38] sel_rf_res
  - [37] rf_we
  - [36:32] rf_waddr
  - [31:0] ex_result (memory address or ALU result)
- data_sram_rdata  in  32  SRAM read word; valid in the cycle after EX issued the address.
- mem_to_wb_bus  out  70  fields:
  - [69:38] pc
  - [37] rf_we
  - [36:32] rf_waddr
  - [31:0] rf_wdata
- mem_to_id  out  38  forwarding: {rf_we, rf_waddr, rf_wdata}.

## Operation
- Pipeline register `ex_to_mem_bus_r`, updated in priority order:
  - rst: cleared to 0.
  - stall[3]=Stop and stall[4]=NoStop: cleared to 0 (bubble).
  - stall[3]=NoStop: loads ex_to_mem_bus.
  - otherwise: holds.
- Load detection: is_load = data_ram_en & (data_ram_wen == 4'b0000) & sel_rf_res.
- load_sel encoding:
  - 0001 lb, 0010 lbu, 0011 lh, 0100 lhu.
  - Any other value on a load is lw.
- Byte select by ex_result[1:0]:
  - 00 → rdata[7:0], 01 → [15:8], 10 → [23:16], 11 → [31:24].
  - lb sign-extends to 32 bits; lbu zero-extends.
- Halfword select by ex_result[1]:
  - 0 → rdata[15:0], 1 → rdata[31:16].
  - lh sign-extends; lhu zero-extends.
  - ex_result[0] is ignored; alignment is checked upstream.
- lw uses the full word.
- rf_wdata = is_load ? extracted data : ex_result.
- Stores and non-memory instructions pass ex_result unchanged.
- Bubbles (all-zero register) give rf_we=0, so write-back and forwarding see no write.

## Timing
- Reset values: mem_to_wb_bus = 0, mem_to_id = 0, load buffer EMPTY, buffer data = 0.
- Outputs are combinational from the register, the SRAM data and the buffer. Latency from EX to WB-bus valid is one cycle.
- Reset asserted mid-hold clears the register and the buffer immediately; no partial load survives.
- A bubble and a new load on consecutive cycles need no idle gap.

## Configuration
- `MEM_LOAD_BUF_EN` defined:
  - Adds a one-entry load buffer with a 2-state FSM (EMPTY, FULL) and a `fresh` flag. `fresh` is set when the register loads and cleared on the next edge.
  - EMPTY→FULL on an edge where is_load, fresh=1 and the register holds (stall[3]=Stop, stall[4]=Stop); data_sram_rdata is captured on that edge.
  - FULL→EMPTY on any register load or bubble, or on rst.
  - While FULL, extraction uses the buffered word, so a multi-cycle MEM stall returns correct load data even if the SRAM output changes.
- `MEM_LOAD_BUF_EN` undefined: no buffer or FSM. Extraction always uses data_sram_rdata, which is correct only if the SRAM holds its output during stalls.

## Structure
- `lib/defines.vh` holds: `EX_TO_MEM_WD`, `MEM_TO_WB_WD`, `StallBus`, `Stop`/`NoStop`, and the load_sel encodings (`LD_LB`, `LD_LBU`, `LD_LH`, `LD_LHU`).
- Sub-module `load_align`: purely combinational. Inputs: rdata, addr[1:0], load_sel. Output: 32-bit extended data. It is reused for checking against the bench model.
- Buffer FSM and pipeline register live in mem_stage.

## Test plan
- lb, addr 0x...03, rdata 0x80FF1234 → rf_wdata 0xFFFFFF80; lbu, same inputs → 0x00000080.
- lh, addr 0x...02, rdata 0x8001ABCD → 0xFFFF8001; lhu, addr 0x...00 → 0x0000ABCD; lw → 0x8001ABCD.
- addu result 0x00000042, rf_we=1, waddr=5 → mem_to_id = {1, 5, 0x42}. sw → rf_we=0 and rf_wdata = address.
- stall[3]=1, stall[4]=0 → next cycle mem_to_wb_bus = 0. stall[3]=1, stall[4]=1 → bus holds its previous value.
- With `MEM_LOAD_BUF_EN`: lw, rdata 0xDEADBEEF in the first cycle, then MEM held 3 cycles while rdata changes to 0x0 → rf_wdata stays 0xDEADBEEF. After release, the buffer is EMPTY.
- Assert rst during a held load → all outputs 0 in the same cycle, the buffer is EMPTY, and the next instruction flows normally.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths, stall encoding, load_sel codes and bus layout for the MEM stage.
package mem_stage_pkg;
    localparam int EX_TO_MEM_WD = 80;
    localparam int MEM_TO_WB_WD = 70;
    localparam int StallBus     = 6;
    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;
    localparam logic [3:0] LD_LB  = 4'b0001;
    localparam logic [3:0] LD_LBU = 4'b0010;
    localparam logic [3:0] LD_LH  = 4'b0011;
    localparam logic [3:0] LD_LHU = 4'b0100;
    typedef enum logic {BUF_EMPTY = 1'b0, BUF_FULL = 1'b1} buf_state_e;
    typedef struct packed {
        logic [3:0]  load_sel;
        logic [31:0] pc;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_to_mem_t;
endpackage

// File: rtl/load_align.sv
// load_align: picks the byte/halfword/word out of an SRAM read word and sign/zero extends it.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [3:0]  load_sel,
    output logic [31:0] data
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b = addr[1] ? (addr[0] ? rdata[31:24] : rdata[23:16])
                    : (addr[0] ? rdata[15:8]  : rdata[7:0]);
        h = addr[1] ? rdata[31:16] : rdata[15:0];
        data = load_sel == LD_LB  ? {{24{b[7]}}, b}  :
               load_sel == LD_LBU ? {24'b0, b}       :
               load_sel == LD_LH  ? {{16{h[15]}}, h} :
               load_sel == LD_LHU ? {16'b0, h}       : rdata;
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MIPS memory stage; registers the EX bus, aligns load data, drives WB bus and ID forwarding.
// MEM_LOAD_BUF_EN adds a one-entry buffer that keeps load data stable across MEM stalls.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [StallBus-1:0]     stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [37:0]             mem_to_id
);
    ex_to_mem_t ex_q;
    logic is_load;
    logic hold;
    logic [31:0] rdata_sel;
    logic [31:0] ld_data;
    logic [31:0] rf_wdata;
    logic unused_stall;

    assign unused_stall = ^{stall[5], stall[2:0]};
    assign hold = stall[3] == Stop && stall[4] == Stop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ex_q <= '0;
        else if (stall[3] == Stop && stall[4] == NoStop) ex_q <= '0;
        else if (stall[3] == NoStop) ex_q <= ex_to_mem_bus;
    end

    assign is_load = ex_q.data_ram_en && ex_q.data_ram_wen == 4'b0000 && ex_q.sel_rf_res;

`ifdef MEM_LOAD_BUF_EN
    buf_state_e state_q, state_d;
    logic fresh_q;
    logic [31:0] buf_q, buf_d;
    logic capture;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BUF_EMPTY;
            fresh_q <= 1'b0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            fresh_q <= stall[3] == NoStop;
            buf_q   <= buf_d;
        end
    end

    // capture only in the first MEM cycle of a load, when the SRAM word is known valid
    always_comb begin
        capture = state_q == BUF_EMPTY && is_load && fresh_q && hold;
        state_d = capture ? BUF_FULL : (state_q == BUF_FULL && !hold) ? BUF_EMPTY : state_q;
        buf_d   = capture ? data_sram_rdata : buf_q;
    end

    assign rdata_sel = state_q == BUF_FULL ? buf_q : data_sram_rdata;
`else
    assign rdata_sel = data_sram_rdata;
`endif

    load_align u_align (
        .rdata    (rdata_sel),
        .addr     (ex_q.ex_result[1:0]),
        .load_sel (ex_q.load_sel),
        .data     (ld_data)
    );

    assign rf_wdata      = is_load ? ld_data : ex_q.ex_result;
    assign mem_to_id     = {ex_q.rf_we, ex_q.rf_waddr, rf_wdata};
    assign mem_to_wb_bus = {ex_q.pc, mem_to_id};
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage; expected WB-bus words are queued at issue and checked one cycle later.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [79:0] ex_to_mem_bus;
    logic [31:0] data_sram_rdata;
    logic [69:0] mem_to_wb_bus;
    logic [37:0] mem_to_id;
    logic [69:0] exp_q[$];
    int n_chk = 0;
    int n_fail = 0;

    localparam logic [5:0] RUN = 6'b000000;
    localparam logic [5:0] BUB = 6'b001000;
    localparam logic [5:0] HLD = 6'b011000;

    mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .data_sram_rdata (data_sram_rdata),
        .mem_to_wb_bus   (mem_to_wb_bus),
        .mem_to_id       (mem_to_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [79:0] mk(input logic [3:0] ls, input logic [31:0] pc, input logic en,
                                       input logic [3:0] wen, input logic sel, input logic we,
                                       input logic [4:0] wa, input logic [31:0] res);
        return {ls, pc, en, wen, sel, we, wa, res};
    endfunction

    function automatic logic [69:0] wb(input logic [31:0] pc, input logic we, input logic [4:0] wa,
                                       input logic [31:0] d);
        return {pc, we, wa, d};
    endfunction

    function automatic logic [31:0] model(input logic [3:0] ls, input logic [1:0] a, input logic [31:0] rd);
        logic [31:0] sb, sh;
        sb = rd >> {a, 3'b000};
        sh = rd >> {a[1], 4'b0000};
        case (ls)
            4'd1: return {{24{sb[7]}}, sb[7:0]};
            4'd2: return {24'h0, sb[7:0]};
            4'd3: return {{16{sh[15]}}, sh[15:0]};
            4'd4: return {16'h0, sh[15:0]};
            default: return rd;
        endcase
    endfunction

    task automatic step(input string tag, input logic [79:0] bus, input logic [5:0] st,
                        input logic [31:0] rd, input logic [69:0] exp);
        logic [69:0] e;
        ex_to_mem_bus = bus;
        stall = st;
        exp_q.push_back(exp);
        @(posedge clk);
        #1 data_sram_rdata = rd;
        @(negedge clk);
        e = exp_q.pop_front();
        check({tag, ".wb"}, mem_to_wb_bus, e);
        check({tag, ".id"}, {32'h0, mem_to_id}, {32'h0, e[37:0]});
    endtask

    initial begin
        logic [3:0]  ls;
        logic [31:0] a, rd, pc;
        logic [79:0] lw_i, add_i;
        rst = 1'b1;
        stall = RUN;
        ex_to_mem_bus = '0;
        data_sram_rdata = '0;
        #1;
        check("reset.wb", mem_to_wb_bus, '0);
        check("reset.id", {32'h0, mem_to_id}, '0);
        @(negedge clk);
        rst = 1'b0;

        step("lb",  mk(4'd1, 32'h100, 1, 4'h0, 1, 1, 5'd2, 32'h1003), RUN, 32'h80FF1234, wb(32'h100, 1, 5'd2, 32'hFFFFFF80));
        step("lbu", mk(4'd2, 32'h104, 1, 4'h0, 1, 1, 5'd2, 32'h1003), RUN, 32'h80FF1234, wb(32'h104, 1, 5'd2, 32'h00000080));
        step("lh",  mk(4'd3, 32'h108, 1, 4'h0, 1, 1, 5'd3, 32'h1002), RUN, 32'h8001ABCD, wb(32'h108, 1, 5'd3, 32'hFFFF8001));
        step("lhu", mk(4'd4, 32'h10C, 1, 4'h0, 1, 1, 5'd3, 32'h1000), RUN, 32'h8001ABCD, wb(32'h10C, 1, 5'd3, 32'h0000ABCD));
        step("lw",  mk(4'd0, 32'h110, 1, 4'h0, 1, 1, 5'd4, 32'h1000), RUN, 32'h8001ABCD, wb(32'h110, 1, 5'd4, 32'h8001ABCD));
        step("addu", mk(4'd0, 32'h114, 0, 4'h0, 0, 1, 5'd5, 32'h42), RUN, 32'h12345678, wb(32'h114, 1, 5'd5, 32'h42));
        step("sw",  mk(4'd0, 32'h118, 1, 4'hF, 1, 0, 5'd0, 32'h2004), RUN, 32'hCAFEF00D, wb(32'h118, 0, 5'd0, 32'h2004));

        for (int i = 0; i < 20; i++) begin
            ls = 4'($urandom_range(0, 6));
            a  = $urandom;
            rd = $urandom;
            pc = $urandom;
            step("rnd_ld", mk(ls, pc, 1, 4'h0, 1, 1, 5'(i + 1), a), RUN, rd, wb(pc, 1, 5'(i + 1), model(ls, a[1:0], rd)));
        end

        add_i = mk(4'd0, 32'h200, 0, 4'h0, 0, 1, 5'd7, 32'h77);
        step("pre_bub", add_i, RUN, 32'h0, wb(32'h200, 1, 5'd7, 32'h77));
        step("bubble", mk(4'd0, 32'h204, 0, 4'h0, 0, 1, 5'd8, 32'h88), BUB, 32'h0, '0);
        step("after_bub", mk(4'd1, 32'h208, 1, 4'h0, 1, 1, 5'd9, 32'h3001), RUN, 32'h0000FF00, wb(32'h208, 1, 5'd9, 32'hFFFFFFFF));
        step("pre_hold", add_i, RUN, 32'h0, wb(32'h200, 1, 5'd7, 32'h77));
        step("hold1", mk(4'd0, 32'h20C, 0, 4'h0, 0, 1, 5'd10, 32'hAA), HLD, 32'h0, wb(32'h200, 1, 5'd7, 32'h77));
        step("hold2", mk(4'd0, 32'h210, 0, 4'h0, 0, 1, 5'd11, 32'hBB), HLD, 32'h0, wb(32'h200, 1, 5'd7, 32'h77));

        lw_i = mk(4'd0, 32'h300, 1, 4'h0, 1, 1, 5'd12, 32'h4000);
`ifdef MEM_LOAD_BUF_EN
        step("buf_lw", lw_i, RUN, 32'hDEADBEEF, wb(32'h300, 1, 5'd12, 32'hDEADBEEF));
        for (int i = 0; i < 3; i++)
            step("buf_hold", add_i, HLD, 32'h0, wb(32'h300, 1, 5'd12, 32'hDEADBEEF));
        step("buf_release", add_i, RUN, 32'h0, wb(32'h200, 1, 5'd7, 32'h77));
        step("buf_empty_lw", lw_i, RUN, 32'h11111111, wb(32'h300, 1, 5'd12, 32'h11111111));
`endif

        step("rst_lw", lw_i, RUN, 32'h55AA55AA, wb(32'h300, 1, 5'd12, 32'h55AA55AA));
        step("rst_hold", add_i, HLD, 32'h55AA55AA, wb(32'h300, 1, 5'd12, 32'h55AA55AA));
        rst = 1'b1;
        #1;
        check("rst_mid.wb", mem_to_wb_bus, '0);
        check("rst_mid.id", {32'h0, mem_to_id}, '0);
        @(negedge clk);
        rst = 1'b0;
        step("post_rst_add", add_i, RUN, 32'h0, wb(32'h200, 1, 5'd7, 32'h77));
        step("post_rst_lw", mk(4'd3, 32'h304, 1, 4'h0, 1, 1, 5'd13, 32'h4002), RUN, 32'h7FFF0000, wb(32'h304, 1, 5'd13, 32'h00007FFF));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
